// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer for the 3x3 convolution datapath. Takes a raster-scan pixel
//   stream, keeps two line buffers and a 3x3 window, and presents the packed
//   window plus a locally stored kernel to the external combinational conv
//   core. Each valid core result is registered onto a single-entry
//   valid/ready output stage; frame_done_o pulses once at end of frame.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             begin a frame (sampled only in IDLE)
//   k_we_i/k_addr_i/k_data_i   kernel coefficient write (IDLE only, addr 0..8)
//   pix_valid_i/pix_i/pix_ready_o   input pixel stream
//   win_o, kernel_o     packed window / kernel to core, [top-left ... bottom-right]
//   conv_res_i          combinational core result
//   out_valid_o/out_data_o/out_ready_i   result stream
//   busy_o              high outside IDLE
//   frame_done_o        one-cycle end-of-frame pulse
//
// Optional feature
//   CONV_SAT8_EN        when defined, results above 255 load as 255.

module conv_window_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8,
  parameter int RES_W = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    k_we_i,
  input  logic [3:0]              k_addr_i,
  input  logic [PIX_W-1:0]        k_data_i,
  input  logic                    pix_valid_i,
  input  logic [PIX_W-1:0]        pix_i,
  output logic                    pix_ready_o,
  output logic [9*PIX_W-1:0]      win_o,
  output logic [9*PIX_W-1:0]      kernel_o,
  input  logic signed [RES_W-1:0] conv_res_i,
  output logic                    out_valid_o,
  output logic [RES_W-1:0]        out_data_o,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic signed [PIX_W-1:0] linebuf0 [IMG_W];
  logic signed [PIX_W-1:0] linebuf1 [IMG_W];
  logic signed [PIX_W-1:0] win      [3][3];
  logic signed [PIX_W-1:0] kern     [9];

  logic                    stall;
  logic                    accept;
  logic                    col_last;
  logic                    last_pix;
  logic                    produce;
  logic signed [PIX_W-1:0] col_top;
  logic signed [PIX_W-1:0] col_mid;

  function automatic logic [RES_W-1:0] sat_res(input logic signed [RES_W-1:0] r);
`ifdef CONV_SAT8_EN
    if (r > $signed(RES_W'(255))) sat_res = RES_W'(255);
    else                          sat_res = r;
`else
    sat_res = r;
`endif
  endfunction

  assign col_top  = linebuf1[col];
  assign col_mid  = linebuf0[col];
  assign stall    = out_valid_o && !out_ready_i;
  assign accept   = pix_valid_i && pix_ready_o;
  assign col_last = (col == COL_LAST);
  assign last_pix = (row == ROW_LAST) && col_last;
  // Only pixels that complete a full 3x3 neighbourhood yield a result.
  assign produce  = accept && (row >= RW'(2)) && (col >= CW'(2));

  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pix_ready_o = 1'b0;
    case (state)
      IDLE:  if (start_i) state_nx = RUN;
      RUN: begin
        pix_ready_o = !stall;
        if (pix_valid_i && !stall && last_pix) state_nx = DRAIN;
      end
      DRAIN: if (!out_valid_o || out_ready_i) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control: raster counters and kernel store (frozen once a frame starts).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      for (int k = 0; k < 9; k++) kern[k] <= '0;
    end else if (state == IDLE) begin
      for (int k = 0; k < 9; k++)
        if (k_we_i && (k_addr_i == 4'(k))) kern[k] <= k_data_i;
      if (start_i) begin
        row <= '0;
        col <= '0;
      end
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage p0: line buffers and window shift on each accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        linebuf0[i] <= '0;
        linebuf1[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (accept) begin
      linebuf1[col] <= col_mid;
      linebuf0[col] <= pix_i;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= col_top;
      win[1][2] <= col_mid;
      win[2][2] <= pix_i;
    end
  end

  // The core sees the window as it will be after this accept: the two newest
  // stored columns plus the incoming column, with pix_i at bottom-right.
  always_comb begin
    win_o    = '0;
    kernel_o = '0;
    for (int k = 0; k < 9; k++) kernel_o[(8-k)*PIX_W +: PIX_W] = kern[k];
    if (state == RUN) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 2; c++)
          win_o[(8-(r*3+c))*PIX_W +: PIX_W] = win[r][c+1];
      win_o[6*PIX_W +: PIX_W] = col_top;
      win_o[3*PIX_W +: PIX_W] = col_mid;
      win_o[0 +: PIX_W]       = pix_i;
    end
  end

  // Stage p1: single-entry output register; a new load wins over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (produce) begin
      out_valid_o <= 1'b1;
      out_data_o  <= sat_res(conv_res_i);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;
  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        k_we = 1'b0;
  logic [3:0]  k_addr = '0;
  logic [7:0]  k_data = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix = '0;
  logic        pix_ready;
  logic [71:0] win;
  logic [71:0] kernel;
  logic [10:0] conv_res;
  logic        out_valid;
  logic [10:0] out_data;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];
  int got_q[$];
  int img[W*H];
  int kern[9];
  int fd_cnt = 0;
  logic        held = 1'b0;
  logic [10:0] held_data = '0;

  always #5 clk = ~clk;

  conv_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .k_we_i(k_we), .k_addr_i(k_addr),
    .k_data_i(k_data), .pix_valid_i(pix_valid), .pix_i(pix), .pix_ready_o(pix_ready),
    .win_o(win), .kernel_o(kernel), .conv_res_i(conv_res), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_ready_i(out_ready), .busy_o(busy), .frame_done_o(frame_done)
  );

  function automatic int sx8(input int v);
    logic signed [7:0] b;
    b = v[7:0];
    return int'(b);
  endfunction

  // External conv core stand-in: per-term floor(p*k/64), summed, ReLU.
  always_comb begin
    int s;
    s = 0;
    for (int k = 0; k < 9; k++)
      s += (sx8(int'(win[(8-k)*8 +: 8])) * sx8(int'(kernel[(8-k)*8 +: 8]))) >>> 6;
    if (s < 0) s = 0;
    conv_res = 11'(s);
  end

  // Expected result for the window whose bottom-right pixel is (r, c).
  function automatic int model(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += (sx8(img[(r-2+i)*W + (c-2+j)]) * sx8(kern[i*3+j])) >>> 6;
    if (s < 0) s = 0;
`ifdef CONV_SAT8_EN
    if (s > 255) s = 255;
`endif
    return s;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (held && out_valid) chk("hold_stable", out_data, held_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got %0d expected none", out_data);
        end else begin
          chk("result", out_data, exp_q.pop_front());
          got_q.push_back(int'(out_data));
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  task automatic wr_coef(input int a, input int d, input bit with_start);
    k_we = 1'b1; k_addr = 4'(a); k_data = 8'(d); start = with_start;
    @(posedge clk); #1;
    k_we = 1'b0; start = 1'b0;
  endtask

  task automatic load_kern(input bit start_with_last);
    for (int a = 0; a < 8; a++) wr_coef(a, kern[a], 1'b0);
    for (int a = 9; a < 16; a++) wr_coef(a, 8'h55 + a, 1'b0);
    wr_coef(8, kern[8], start_with_last);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < W*H; i++) img[i] = i;
  endtask

  task automatic set_kern(input int centre, input int right, input int others);
    for (int k = 0; k < 9; k++) kern[k] = others;
    kern[4] = centre;
    if (right >= 0) kern[5] = right;
  endtask

  task automatic feed(input bit bp, input bit poke, input int stop_at);
    int idx, guard, hold;
    bit acc, seen;
    idx = 0; guard = 0; hold = 0; seen = 1'b0;
    while (idx < W*H && guard < 4000) begin
      if (stop_at >= 0 && idx == stop_at) break;
      pix_valid = 1'b1;
      pix = 8'(img[idx]);
      if (poke && idx == 10) begin
        k_we = 1'b1; k_addr = 4'd4; k_data = 8'h00; start = 1'b1;
      end else begin
        k_we = 1'b0; start = 1'b0;
      end
      if (bp && out_valid && hold < 6) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      acc = pix_ready;
      if (bp && hold == 1 && !seen) begin
        chk("bp_ready_drop", pix_ready, 0);
        chk("bp_hold_data", out_data, 9);
        seen = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    pix_valid = 1'b0; k_we = 1'b0; start = 1'b0; out_ready = 1'b1;
    if (guard >= 4000) chk("feed_timeout", guard, 0);
    if (bp) chk("bp_seen", seen, 1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_after_frame", busy, 0);
  endtask

  task automatic prep_expect();
    got_q.delete();
    exp_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) exp_q.push_back(model(r, c));
  endtask

  task automatic do_frame(input bit already_started, input bit bp, input bit poke);
    int fd0;
    fd0 = fd_cnt;
    if (!already_started) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("busy_in_run", busy, 1);
    feed(bp, poke, -1);
    wait_idle();
    chk("frame_done_pulses", fd_cnt - fd0, 1);
    chk("result_count", got_q.size(), 36);
    chk("leftover_expected", exp_q.size(), 0);
  endtask

  task automatic chk_ends(input int first, input int last);
    if (got_q.size() == 36) begin
      chk("first_result", got_q[0], first);
      chk("last_result", got_q[35], last);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_kernel"}, kernel, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    logic [71:0] kexp;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity kernel on a ramp image; junk writes to 9..15 must not land.
    set_ramp();
    set_kern(8'h40, -1, 0);
    load_kern(1'b0);
    kexp = 72'h40;
    kexp = kexp << 32;
    chk("kernel_identity", kernel, kexp);
    prep_expect();
    do_frame(1'b0, 1'b0, 1'b0);
    chk_ends(9, 54);

    // Box kernel; the last coefficient write shares its cycle with start.
    set_kern(8'h08, -1, 8'h08);
    prep_expect();
    load_kern(1'b1);
    do_frame(1'b1, 1'b0, 1'b0);
    if (got_q.size() > 0) chk("box_first", got_q[0], 9);

    // Negative centre coefficient: core clamps to zero.
    set_kern(8'hC0, -1, 0);
    load_kern(1'b0);
    prep_expect();
    do_frame(1'b0, 1'b0, 1'b0);
    chk_ends(0, 0);

    // Large sums: 252 + 127 = 379.
    for (int i = 0; i < W*H; i++) img[i] = 8'h7F;
    set_kern(8'h7F, 8'h40, 0);
    load_kern(1'b0);
    prep_expect();
    do_frame(1'b0, 1'b0, 1'b0);
`ifdef CONV_SAT8_EN
    chk_ends(255, 255);
`else
    chk_ends(379, 379);
`endif

    // Backpressure after the first result.
    set_ramp();
    set_kern(8'h40, -1, 0);
    load_kern(1'b0);
    prep_expect();
    do_frame(1'b0, 1'b1, 1'b0);
    chk_ends(9, 54);

    // Kernel write and start during RUN are ignored.
    prep_expect();
    do_frame(1'b0, 1'b0, 1'b1);
    chk_ends(9, 54);
    chk("kernel_kept", kernel, kexp);

    // Asynchronous reset mid-frame at pixel 30.
    prep_expect();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(1'b0, 1'b0, 30);
    chk("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #2;
    chk_zero_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reload and rerun the identity frame.
    load_kern(1'b0);
    chk("kernel_reloaded", kernel, kexp);
    prep_expect();
    do_frame(1'b0, 1'b0, 1'b0);
    chk_ends(9, 54);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
